// File: rtl/fp_round_pipe_pkg.sv
// Shared constants for the FP rounding stage: default widths, rounding-mode
// codes and the overflow saturation rule used by every rounding consumer.
package fp_round_pipe_pkg;

    localparam int WSIG_DEF = 23;
    localparam int WEXP_DEF = 8;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RZ  = 2'b01,
        RM_RP  = 2'b10,
        RM_RM  = 2'b11
    } round_mode_e;

    // On overflow a mode either saturates to infinity or clamps to max finite.
    function automatic logic sat_to_inf(input round_mode_e mode, input logic sign);
        return (mode == RM_RNE) || ((mode == RM_RP) && !sign) || ((mode == RM_RM) && sign);
    endfunction

endpackage

// File: rtl/fp_round_pipe_if.sv
// Valid/ready beat interface of the rounding pipeline: normaliser-side input
// beat and packer-side output beat.
interface fp_round_pipe_if
    import fp_round_pipe_pkg::*;
#(
    parameter int WSIG = WSIG_DEF,
    parameter int WEXP = WEXP_DEF
);
    logic            in_valid;
    logic            in_ready;
    logic [WSIG-1:0] normsum;
    logic            round;
    logic            sticky;
    logic            finalsign;
    logic [WEXP-1:0] overexp;
    logic [1:0]      roundmode;

    logic            out_valid;
    logic            out_ready;
    logic [WSIG-1:0] roundsum;
    logic [WEXP:0]   exp;
    logic            roundshift;
    logic            inexact;
    logic            overflow;

    modport slave (
        input  in_valid, normsum, round, sticky, finalsign, overexp, roundmode, out_ready,
        output in_ready, out_valid, roundsum, exp, roundshift, inexact, overflow
    );

    modport master (
        output in_valid, normsum, round, sticky, finalsign, overexp, roundmode, out_ready,
        input  in_ready, out_valid, roundsum, exp, roundshift, inexact, overflow
    );
endinterface

// File: rtl/fp_round_pipe_round_decide.sv
// Round-up decision shared by the adder, multiplier and divider rounding
// stages: whether to add one ulp given lsb, guard/sticky, sign and mode.
module round_decide
    import fp_round_pipe_pkg::*;
(
    input  logic       i_lsb,
    input  logic       i_round,
    input  logic       i_sticky,
    input  logic       i_finalsign,
    input  logic [1:0] i_roundmode,
    output logic       o_addone
);

    always_comb begin
        o_addone = 1'b0;
        case (round_mode_e'(i_roundmode))
            RM_RNE:  o_addone = i_round & (i_sticky | i_lsb);
            RM_RZ:   o_addone = 1'b0;
            RM_RP:   o_addone = ~i_finalsign & (i_round | i_sticky);
            RM_RM:   o_addone = i_finalsign & (i_round | i_sticky);
            default: o_addone = 1'b0;
        endcase
    end

endmodule

// File: rtl/fp_round_pipe.sv
// Two-stage valid/ready rounding pipeline: stage 1 decides and applies the
// increment, stage 2 forms the final exponent and saturates on overflow.
module fp_round_pipe
    import fp_round_pipe_pkg::*;
#(
    parameter int WSIG = WSIG_DEF,
    parameter int WEXP = WEXP_DEF
)(
    input  logic             clk,
    input  logic             rst_n,
    fp_round_pipe_if.slave   bus
);

    localparam logic [WEXP:0] EXP_MAX    = {1'b0, {WEXP{1'b1}}};
    localparam logic [WEXP:0] EXP_MAXFIN = {1'b0, {(WEXP-1){1'b1}}, 1'b0};
    localparam logic [WEXP:0] EXP_ONE    = (WEXP+1)'(1);
    localparam logic [WEXP:0] EXP_TWO    = (WEXP+1)'(2);
    localparam logic [WSIG:0] SIG_ONE    = (WSIG+1)'(1);

    logic            r_s1_valid;
    logic [WSIG-1:0] r_s1_rsum;
    logic            r_s1_rshift;
    logic [WEXP-1:0] r_s1_overexp;
    logic            r_s1_sign;
    round_mode_e     r_s1_mode;
    logic            r_s1_inexact;

    logic            r_s2_valid;
    logic [WSIG-1:0] r_roundsum;
    logic [WEXP:0]   r_exp;
    logic            r_roundshift;
    logic            r_inexact;
    logic            r_overflow;

    logic            w_s2_load;
    logic            w_s1_load;
    logic            w_addone;
    logic [WSIG:0]   w_sum1;
    logic [WEXP:0]   w_e;
    logic            w_ovf;
    logic [WSIG-1:0] w_roundsum_next;
    logic [WEXP:0]   w_exp_next;
    logic            w_inexact_next;

    // Ready ripples back combinationally so a full pipe still streams at one beat per cycle.
    assign w_s2_load = ~r_s2_valid | bus.out_ready;
    assign w_s1_load = ~r_s1_valid | w_s2_load;

    round_decide u_round_decide (
        .i_lsb       (bus.normsum[0]),
        .i_round     (bus.round),
        .i_sticky    (bus.sticky),
        .i_finalsign (bus.finalsign),
        .i_roundmode (bus.roundmode),
        .o_addone    (w_addone)
    );

    assign w_sum1 = {1'b0, bus.normsum} + SIG_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_rsum    <= '0;
            r_s1_rshift  <= 1'b0;
            r_s1_overexp <= '0;
            r_s1_sign    <= 1'b0;
            r_s1_mode    <= RM_RNE;
            r_s1_inexact <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_rsum    <= w_addone ? w_sum1[WSIG-1:0] : bus.normsum;
                r_s1_rshift  <= w_addone & w_sum1[WSIG];
                r_s1_overexp <= bus.overexp;
                r_s1_sign    <= bus.finalsign;
                r_s1_mode    <= round_mode_e'(bus.roundmode);
                r_s1_inexact <= bus.round | bus.sticky;
            end
        end
    end

    // Exponent is one wider than the field, so the +2 never wraps.
    assign w_e   = {1'b0, r_s1_overexp} + (r_s1_rshift ? EXP_TWO : EXP_ONE);
    assign w_ovf = (w_e >= EXP_MAX);

    always_comb begin
        w_roundsum_next = r_s1_rsum;
        w_exp_next      = w_e;
        w_inexact_next  = r_s1_inexact;
        if (w_ovf) begin
            w_inexact_next = 1'b1;
            if (sat_to_inf(r_s1_mode, r_s1_sign)) begin
                w_exp_next      = EXP_MAX;
                w_roundsum_next = '0;
            end else begin
                w_exp_next      = EXP_MAXFIN;
                w_roundsum_next = '1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid   <= 1'b0;
            r_roundsum   <= '0;
            r_exp        <= '0;
            r_roundshift <= 1'b0;
            r_inexact    <= 1'b0;
            r_overflow   <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_roundsum   <= w_roundsum_next;
                r_exp        <= w_exp_next;
                r_roundshift <= r_s1_rshift;
                r_inexact    <= w_inexact_next;
                r_overflow   <= w_ovf;
            end
        end
    end

    assign bus.in_ready   = w_s1_load;
    assign bus.out_valid  = r_s2_valid;
    assign bus.roundsum   = r_roundsum;
    assign bus.exp        = r_exp;
    assign bus.roundshift = r_roundshift;
    assign bus.inexact    = r_inexact;
    assign bus.overflow   = r_overflow;

endmodule

// File: tb/tb_fp_round_pipe.sv
// Scoreboard bench for fp_round_pipe: directed corner beats, back-pressure,
// mid-stream reset and randomized traffic against an arithmetic rounding model.
module tb_fp_round_pipe;
    import fp_round_pipe_pkg::*;

    localparam int WSIG = 23;
    localparam int WEXP = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_round_pipe_if #(.WSIG(WSIG), .WEXP(WEXP)) bus();

    fp_round_pipe #(.WSIG(WSIG), .WEXP(WEXP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [WSIG-1:0] normsum;
        logic            rnd;
        logic            sticky;
        logic            sign;
        logic [WEXP-1:0] overexp;
        logic [1:0]      mode;
    } beat_t;

    typedef struct packed {
        logic [WSIG-1:0] sig;
        logic [WEXP:0]   e;
        logic            sh;
        logic            inx;
        logic            ovf;
    } res_t;

    res_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ready_mode = 0;
    int   out_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Value-level rounding: treat round/sticky as a fraction in quarters of an ulp.
    function automatic res_t model(input beat_t b);
        res_t r;
        int   top, frac, inc, m, carry, e;
        bit   ovf, to_inf;
        top  = 1 << WSIG;
        frac = 2 * int'(b.rnd) + int'(b.sticky);
        case (b.mode)
            2'b00:   inc = (frac > 2 || (frac == 2 && (int'(b.normsum) % 2) == 1)) ? 1 : 0;
            2'b01:   inc = 0;
            2'b10:   inc = (!b.sign && frac != 0) ? 1 : 0;
            default: inc = (b.sign && frac != 0) ? 1 : 0;
        endcase
        m     = int'(b.normsum) + inc;
        carry = (m >= top) ? 1 : 0;
        e     = int'(b.overexp) + 1 + carry;
        ovf   = (e >= (1 << WEXP) - 1);
        r.sh  = (carry == 1);
        r.inx = (frac != 0) || ovf;
        r.ovf = ovf;
        if (ovf) begin
            to_inf = (b.mode == 2'b00) || (b.mode == 2'b10 && !b.sign) || (b.mode == 2'b11 && b.sign);
            r.e   = to_inf ? (WEXP+1)'((1 << WEXP) - 1) : (WEXP+1)'((1 << WEXP) - 2);
            r.sig = to_inf ? '0 : WSIG'(top - 1);
        end else begin
            r.e   = (WEXP+1)'(e);
            r.sig = WSIG'(m % top);
        end
        return r;
    endfunction

    function automatic beat_t mk(input int ns, input bit rb, input bit sb, input bit sg,
                                 input int oe, input int md);
        beat_t b;
        b.normsum = WSIG'(ns);
        b.rnd     = rb;
        b.sticky  = sb;
        b.sign    = sg;
        b.overexp = WEXP'(oe);
        b.mode    = 2'(md);
        return b;
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        b.normsum = ($urandom_range(0, 7) == 0) ? '1 : WSIG'($urandom);
        b.rnd     = 1'($urandom);
        b.sticky  = 1'($urandom);
        b.sign    = 1'($urandom);
        b.overexp = ($urandom_range(0, 3) == 0) ? WEXP'($urandom_range(250, 254))
                                                 : WEXP'($urandom_range(0, 254));
        b.mode    = 2'($urandom);
        return b;
    endfunction

    // Present a beat from posedge+1; the transfer is decided by in_ready before the next edge.
    task automatic send(input beat_t b);
        bit accepted;
        int guard;
        accepted = 1'b0;
        guard = 0;
        bus.in_valid  = 1'b1;
        bus.normsum   = b.normsum;
        bus.round     = b.rnd;
        bus.sticky    = b.sticky;
        bus.finalsign = b.sign;
        bus.overexp   = b.overexp;
        bus.roundmode = b.mode;
        while (!accepted && guard < 200) begin
            @(negedge clk);
            accepted = bus.in_ready;
            @(posedge clk);
            #1;
            if (accepted) exp_q.push_back(model(b));
            guard++;
        end
        if (!accepted) check("send_timeout", bus.in_ready, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        ready_mode = 0;
        while (exp_q.size() != 0 && g < 1000) begin
            @(posedge clk);
            g++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic latency_check(input string name);
        check({name, "_lat_c1"}, bus.out_valid, 0);
        @(posedge clk);
        #1;
        check({name, "_lat_c2"}, bus.out_valid, 1);
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ($urandom_range(0, 3) != 0);
            default: bus.out_ready = 1'b0;
        endcase
    end

    res_t held;
    bit   held_v = 1'b0;
    always @(negedge clk) begin
        res_t act;
        res_t want;
        if (!rst_n) begin
            held_v = 1'b0;
        end else if (bus.out_valid) begin
            act = {bus.roundsum, bus.exp, bus.roundshift, bus.inexact, bus.overflow};
            if (held_v) check("stall_hold", act, held);
            if (bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", bus.out_valid, 0);
                end else begin
                    want = exp_q.pop_front();
                    check($sformatf("beat%0d", out_cnt), act, want);
                    $display("beat%0d sig=%h exp=%h sh=%b inx=%b ovf=%b", out_cnt,
                             act.sig, act.e, act.sh, act.inx, act.ovf);
                end
                out_cnt++;
                held_v = 1'b0;
            end else begin
                held   = act;
                held_v = 1'b1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.normsum   = '0;
        bus.round     = 1'b0;
        bus.sticky    = 1'b0;
        bus.finalsign = 1'b0;
        bus.overexp   = '0;
        bus.roundmode = 2'b00;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {bus.out_valid, bus.roundsum, bus.exp, bus.roundshift, bus.inexact, bus.overflow}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_reset", bus.in_ready, 1);

        // RN tie to even keeps the even significand; also measures latency
        send(mk(32'h000002, 1, 0, 0, 8'h40, 0));
        latency_check("rn_tie");
        send(mk(32'h7FFFFF, 1, 1, 0, 8'h80, 0));
        send(mk(32'h000010, 0, 1, 0, 8'h20, 2));
        send(mk(32'h000010, 0, 1, 0, 8'h20, 3));
        send(mk(32'h000010, 1, 1, 0, 8'h20, 1));
        send(mk(32'h7FFFFF, 1, 0, 0, 8'hFD, 0));
        send(mk(32'h7FFFFF, 1, 0, 0, 8'hFD, 1));
        send(mk(32'h7FFFFF, 1, 0, 0, 8'hFD, 3));
        send(mk(32'h123456, 0, 0, 0, 8'hFE, 1));
        send(mk(32'h123456, 0, 1, 0, 8'hFE, 2));
        send(mk(32'h000001, 0, 1, 1, 8'hFE, 2));
        wait_drain();

        // Back-pressure: stall the output for four cycles while beats keep arriving
        fork
            begin
                for (int i = 0; i < 6; i++) send(rand_beat());
            end
            begin
                repeat (3) @(posedge clk);
                ready_mode = 2;
                repeat (2) @(posedge clk);
                for (int k = 0; k < 2; k++) begin
                    @(negedge clk);
                    check("bp_in_ready", bus.in_ready, 0);
                    check("bp_out_valid", bus.out_valid, 1);
                end
                ready_mode = 0;
            end
        join
        wait_drain();

        // Reset with two beats in flight
        ready_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        send(rand_beat());
        send(rand_beat());
        #3;
        rst_n = 1'b0;
        #1;
        check("midreset_outputs",
              {bus.out_valid, bus.roundsum, bus.exp, bus.roundshift, bus.inexact, bus.overflow}, 0);
        exp_q.delete();
        ready_mode = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_midreset", bus.in_ready, 1);
        send(mk(32'h2AAAAA, 1, 1, 1, 8'h10, 3));
        latency_check("post_reset");
        wait_drain();

        // Randomized traffic with random downstream stalls
        ready_mode = 1;
        for (int i = 0; i < 300; i++) send(rand_beat());
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
